// File: rtl/receptor_flash_ctrl.sv
// Per-lane receptor brightness sequencer: press -> hold at peak -> frame-paced decay -> idle.
// Keys and frame_clk are synchronized locally; every output is a register.
module receptor_flash_ctrl #(
  parameter int         NUM_LANES   = 4,
  parameter logic [7:0] PEAK        = 8'hFF,
  parameter logic [7:0] BASE        = 8'h55,
  parameter int         HOLD_FRAMES = 4,
  parameter logic [7:0] DECAY_STEP  = 8'h20
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [NUM_LANES-1:0]   keys,
  output logic [8*NUM_LANES-1:0] flash_level,
  output logic [NUM_LANES-1:0]   is_receptor_lit,
  output logic [NUM_LANES-1:0]   press_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HOLD    = 2'd2,
    DECAY   = 2'd3
  } lane_state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);

  logic [NUM_LANES-1:0] keys_p0;
  logic [NUM_LANES-1:0] keys_p1;
  logic [NUM_LANES-1:0] keys_p2;
  logic [NUM_LANES-1:0] press_p2;
  logic [NUM_LANES-1:0] held_p2;
  logic                 frame_p0;
  logic                 frame_p1;
  logic                 frame_p2;
  logic                 tick_p2;

  lane_state_t          state    [NUM_LANES];
  logic [7:0]           level    [NUM_LANES];
  logic [3:0]           hold_cnt [NUM_LANES];
  logic [NUM_LANES-1:0] lit_r;
  logic [NUM_LANES-1:0] pulse_r;

  // One decay step, clamped so the level lands exactly on BASE instead of undershooting.
  function automatic logic [7:0] decay_sat(input logic [7:0] lvl);
    logic [7:0] above;
    above = lvl - BASE;
    if (above > DECAY_STEP)
      return lvl - DECAY_STEP;
    return BASE;
  endfunction

  // Stage p0/p1: two-flop synchronizers; stage p2: edge detect registered with the held level
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keys_p0  <= '0;
      keys_p1  <= '0;
      keys_p2  <= '0;
      press_p2 <= '0;
      held_p2  <= '0;
      frame_p0 <= 1'b0;
      frame_p1 <= 1'b0;
      frame_p2 <= 1'b0;
      tick_p2  <= 1'b0;
    end else begin
      keys_p0  <= keys;
      keys_p1  <= keys_p0;
      keys_p2  <= keys_p1;
      press_p2 <= keys_p1 & ~keys_p2;
      held_p2  <= keys_p1;
      frame_p0 <= frame_clk;
      frame_p1 <= frame_p0;
      frame_p2 <= frame_p1;
      tick_p2  <= frame_p1 & ~frame_p2;
    end
  end

  // Lane FSMs: a press edge preempts any frame tick arriving in the same cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state[i]    <= IDLE;
        level[i]    <= BASE;
        hold_cnt[i] <= '0;
      end
      lit_r   <= '0;
      pulse_r <= '0;
    end else begin
      pulse_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (press_p2[i] && state[i] != PRESSED) begin
          state[i]    <= PRESSED;
          level[i]    <= PEAK;
          hold_cnt[i] <= '0;
          lit_r[i]    <= 1'b1;
          pulse_r[i]  <= 1'b1;
        end else begin
          case (state[i])
            IDLE: begin
              level[i] <= BASE;
              lit_r[i] <= 1'b0;
            end
            PRESSED: begin
              if (!held_p2[i]) begin
                state[i]    <= HOLD;
                hold_cnt[i] <= HOLD_INIT;
              end
            end
            HOLD: begin
              if (tick_p2) begin
                if (hold_cnt[i] == 4'd1) begin
                  state[i]    <= DECAY;
                  hold_cnt[i] <= '0;
                end else begin
                  hold_cnt[i] <= hold_cnt[i] - 4'd1;
                end
              end
            end
            DECAY: begin
              if (tick_p2) begin
                level[i] <= decay_sat(level[i]);
                if (decay_sat(level[i]) == BASE) begin
                  state[i] <= IDLE;
                  lit_r[i] <= 1'b0;
                end
              end
            end
            default: begin
              state[i] <= IDLE;
              level[i] <= BASE;
              lit_r[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_level
    assign flash_level[8*g +: 8] = level[g];
  end

  assign is_receptor_lit = lit_r;
  assign press_pulse     = pulse_r;

endmodule

// File: tb/tb_receptor_flash_ctrl.sv
// Directed bench for receptor_flash_ctrl: lane 0 timeline from a vector table,
// then hand-written reset, re-press, press/tick collision and two-lane sequences.
module tb_receptor_flash_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk;
  logic [3:0]  keys;
  logic [31:0] flash_level;
  logic [3:0]  is_receptor_lit;
  logic [3:0]  press_pulse;

  int total = 0;
  int bad   = 0;

  receptor_flash_ctrl dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .keys           (keys),
    .flash_level    (flash_level),
    .is_receptor_lit(is_receptor_lit),
    .press_pulse    (press_pulse)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [3:0]  k;
    logic        f;
    logic [31:0] lvl;
    logic [3:0]  lit;
    logic [3:0]  pls;
  } vec_t;

  vec_t       tbl [14];
  logic [7:0] seq [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] lvl,
                            input logic [3:0] lit, input logic [3:0] pls);
    chk({tag, ".level"}, flash_level, lvl);
    chk({tag, ".lit"}, 32'(is_receptor_lit), 32'(lit));
    chk({tag, ".pulse"}, 32'(press_pulse), 32'(pls));
  endtask

  // Drop frame_clk and settle, then apply keys/frame_clk and wait for the 4-edge path.
  task automatic step(input logic [3:0] k, input logic f);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    keys      = k;
    frame_clk = f;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'h1, 1'b0, 32'h555555FF, 4'h1, 4'h1};
    tbl[1]  = '{4'h1, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[2]  = '{4'h1, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[3]  = '{4'h0, 1'b0, 32'h555555FF, 4'h1, 4'h0};
    tbl[4]  = '{4'h0, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[5]  = '{4'h0, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[6]  = '{4'h0, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[7]  = '{4'h0, 1'b1, 32'h555555FF, 4'h1, 4'h0};
    tbl[8]  = '{4'h0, 1'b1, 32'h555555DF, 4'h1, 4'h0};
    tbl[9]  = '{4'h0, 1'b1, 32'h555555BF, 4'h1, 4'h0};
    tbl[10] = '{4'h0, 1'b1, 32'h5555559F, 4'h1, 4'h0};
    tbl[11] = '{4'h0, 1'b1, 32'h5555557F, 4'h1, 4'h0};
    tbl[12] = '{4'h0, 1'b1, 32'h5555555F, 4'h1, 4'h0};
    tbl[13] = '{4'h0, 1'b1, 32'h55555555, 4'h0, 4'h0};
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h55};

    // Reset with all keys held: no pulse until release, then all lanes after 4 edges
    Reset_n   = 1'b0;
    keys      = 4'hF;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    expect_out("rst", 32'h55555555, 4'h0, 4'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("rel_edge%0d.pulse", e), 32'(press_pulse), 32'h0);
    end
    @(posedge Clk);
    #1;
    expect_out("rel_press", 32'hFFFFFFFF, 4'hF, 4'hF);
    @(posedge Clk);
    #1;
    chk("rel_pulse_width", 32'(press_pulse), 32'h0);
    step(4'h0, 1'b0);
    expect_out("all_hold", 32'hFFFFFFFF, 4'hF, 4'h0);
    step(4'h0, 1'b1);
    expect_out("all_hold_t1", 32'hFFFFFFFF, 4'hF, 4'h0);

    // Asynchronous reset mid-HOLD
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    expect_out("midhold_rst", 32'h55555555, 4'h0, 4'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("post_rst%0d.pulse", c), 32'(press_pulse), 32'h0);
    end
    chk("post_rst.level", flash_level, 32'h55555555);

    // Lane 0 full timeline
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].k, tbl[i].f);
      expect_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].lit, tbl[i].pls);
    end

    // Lane 2 re-pressed at 9F during decay
    step(4'h4, 1'b0);
    expect_out("l2_press", 32'h55FF5555, 4'h4, 4'h4);
    step(4'h0, 1'b0);
    for (int j = 0; j < 7; j++) step(4'h0, 1'b1);
    expect_out("l2_at9f", 32'h559F5555, 4'h4, 4'h0);
    step(4'h4, 1'b0);
    expect_out("l2_repress", 32'h55FF5555, 4'h4, 4'h4);
    @(posedge Clk);
    #1;
    chk("l2_pulse_width", 32'(press_pulse), 32'h0);
    step(4'h0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step(4'h0, 1'b1);
      expect_out($sformatf("l2_seq%0d", j), {8'h55, seq[j], 16'h5555},
                 (seq[j] != 8'h55) ? 4'h4 : 4'h0, 4'h0);
    end

    // Lane 1 press edge and frame tick in the same cycle during decay
    step(4'h2, 1'b0);
    step(4'h0, 1'b0);
    for (int j = 0; j < 5; j++) step(4'h0, 1'b1);
    expect_out("l1_decay", 32'h5555DF55, 4'h2, 4'h0);
    step(4'h2, 1'b1);
    expect_out("l1_collide", 32'h5555FF55, 4'h2, 4'h2);
    step(4'h0, 1'b0);
    for (int j = 0; j < 10; j++) step(4'h0, 1'b1);
    expect_out("l1_idle", 32'h55555555, 4'h0, 4'h0);

    // Lanes 0 and 3 pressed two frames apart, released together
    step(4'h1, 1'b0);
    expect_out("l0_press", 32'h555555FF, 4'h1, 4'h1);
    step(4'h1, 1'b1);
    step(4'h1, 1'b1);
    step(4'h9, 1'b0);
    expect_out("l3_press", 32'hFF5555FF, 4'h9, 4'h8);
    step(4'h9, 1'b1);
    step(4'h0, 1'b0);
    expect_out("l03_release", 32'hFF5555FF, 4'h9, 4'h0);
    for (int j = 0; j < 10; j++) begin
      step(4'h0, 1'b1);
      expect_out($sformatf("l03_seq%0d", j), {seq[j], 16'h5555, seq[j]},
                 (seq[j] != 8'h55) ? 4'h9 : 4'h0, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receptor_flash_ctrl.md
# receptor_flash_ctrl

Per-lane controller that sequences the brightness of the four receptor arrows in response to player key presses. It sits between the keyboard decode logic and the pixel color path. Each lane runs its own state machine: pressed, post-release hold, frame-paced decay, idle. Each lane outputs an 8-bit intensity and a lit flag, which the color mapper uses in place of fixed receptor colors.

## Interface
- NUM_LANES, 4, number of receptor lanes; fixed at 4 for this design.
- PEAK, 8'hFF, intensity while pressed; must satisfy PEAK > BASE.
- BASE, 8'h55, idle intensity; matches the existing receptor base color.
- HOLD_FRAMES, 4, frames at PEAK after release before decay starts (1..15).
- DECAY_STEP, 8'h20, intensity decrement per frame during decay (nonzero).

- Clk  in  1  system clock. One clock; all logic in this domain.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vertical sync, asynchronous to Clk's logic; sampled internally.
- keys  in  4  level-high held keys, bit i = lane i; not synchronized externally.
- flash_level  out  32  lane i intensity on bits [8i+7:8i].
- is_receptor_lit  out  4  lane i is not IDLE.
- press_pulse  out  4  one-Clk pulse per lane on each new press.

## Operation
- Input sampling:
  - keys pass through a 2-flop synchronizer to give keys_s. Held-key level is keys_s.
  - A third flop gives keys_p. Press edge for lane i is keys_s[i] & ~keys_p[i].
  - frame_clk uses the same 3-flop structure. frame_tick = rising edge of the synchronized frame_clk, one Clk wide.
- Per-lane FSM. Registers: state, 8-bit level, 4-bit hold counter.
  - IDLE: level=BASE, lit=0.
    - Press edge → PRESSED, level=PEAK.
  - PRESSED: level=PEAK.
    - While the key is held, stay in PRESSED. Frame ticks are ignored.
    - Key released (keys_s[i]=0) → HOLD, counter=HOLD_FRAMES.
  - HOLD: level=PEAK.
    - Each frame_tick decrements the counter.
    - On a frame_tick with counter==1 → DECAY.
  - DECAY: on each frame_tick:
    - If level − BASE > DECAY_STEP, then level -= DECAY_STEP.
    - Otherwise level=BASE and state → IDLE on the same update.
- Re-press:
  - A press edge in HOLD or DECAY → PRESSED, level=PEAK immediately, counter cleared.
  - A press edge while already PRESSED cannot occur unless a release was seen first.
- Simultaneous events:
  - Press edge and frame_tick in the same cycle: the press wins and the tick is ignored for that lane.
  - Release and frame_tick in the same cycle in PRESSED: go to HOLD with counter=HOLD_FRAMES. The tick is not counted.
- Lanes are fully independent. Any subset may be active in the same cycle.
- Arithmetic:
  - The subtraction is 8-bit unsigned. The comparison uses level − BASE, which is never negative because level ≥ BASE is invariant.
  - level never drops below BASE and never exceeds PEAK.
- Reset (Reset_n=0, any time including mid-decay):
  - All lanes go to IDLE immediately (asynchronously), level=BASE, counter=0.
  - Synchronizer flops go to 0.
  - A key still held at reset release produces a press edge after synchronization; this is intended.

## Timing
- Reset values:
  - flash_level = {4{BASE}} (32'h55555555).
  - is_receptor_lit = 4'b0000.
  - press_pulse = 4'b0000.
- Key latency: a keys bit rising before Clk edge N gives press_pulse=1, level=PEAK and lit=1 after edge N+3 (two synchronizer flops, one edge flop, then the registered FSM).
- press_pulse is high for exactly one Clk per press edge.
- Release latency is the same 3-edge path: state changes to HOLD after edge N+3.
- Frame latency: a frame_tick is registered one cycle after the synchronized rising edge of frame_clk. All lane updates for a given frame occur in the same Clk cycle.
- Post-release timeline: PEAK is held for exactly HOLD_FRAMES frame ticks, then one decrement per tick.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset → flash_level=32'h55555555, lit=0, pulse=0. Hold keys=4'hF during reset → no pulse until Reset_n rises. Then 4'hF pulse at +3 edges.
- Lane 0 press, hold 10 frames, release (defaults) →
  - PEAK for 4 ticks after release.
  - Then levels DF, BF, 9F, 7F, 5F, 55 on ticks 5..10.
  - lit drops on tick 10 (IDLE).
- Lane 2 re-pressed at level 9F during DECAY → next update level=FF, state PRESSED, single pulse; after release the full hold/decay sequence restarts.
- Force a press edge and frame_tick in the same cycle on lane 1 during DECAY → level=FF, no decrement applied.
- Lanes 0 and 3 pressed 2 frames apart, released together → independent sequences, offset correct. Lanes 1 and 2 stay at 55, lit=0.
- Assert Reset_n=0 mid-HOLD on all lanes → all outputs at reset values immediately. No pulse after deassert if keys=0.
